// File: rtl/branch_predictor_btb_pkg.sv
// riscv_bp_pkg: counter encodings and BTB entry layout shared by the branch predictor.
package riscv_bp_pkg;
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;
  localparam logic [1:0] CTR_RST = CTR_WNT;
  // Fields are sized for the widest supported build; narrower builds zero-extend into them.
  localparam int XLEN_MAX  = 64;
  localparam int TAG_W_MAX = 32;
  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    logic [XLEN_MAX-1:0]  target;
    logic [1:0]           ctr;
  } bp_entry_t;
endpackage

// File: rtl/branch_predictor_btb_if.sv
// branch_predictor_btb_if: IF-stage lookup and EX-stage resolution signals of the predictor.
interface branch_predictor_btb_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] if_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_valid;
  logic            ex_is_branch;
  logic [XLEN-1:0] ex_pc;
  logic            ex_taken;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  modport master (
    output if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    input  pred_hit, pred_taken, pred_target, mispredict, redirect_pc
  );
  modport slave (
    input  if_pc, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
    output pred_hit, pred_taken, pred_target, mispredict, redirect_pc
  );
endinterface

// File: rtl/branch_predictor_btb_sat_counter2.sv
// sat_counter2: next state of a 2-bit saturating taken/not-taken counter.
module sat_counter2
  import riscv_bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);
  always_comb
    ctr_next = taken ? ((ctr == CTR_ST) ? CTR_ST : ctr + 2'd1)
                     : ((ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1);
endmodule

// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb: direct-mapped BTB with 2-bit counters, mispredict flush and redirect.
// Define BP_PERF_CNT_EN to add the perf_lookups / perf_mispredicts counters.
module branch_predictor_btb
  import riscv_bp_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 10
) (
  input  logic        clk,
  input  logic        rst,
`ifdef BP_PERF_CNT_EN
  output logic [31:0] perf_lookups,
  output logic [31:0] perf_mispredicts,
`endif
  branch_predictor_btb_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  bp_entry_t             tbl_q [ENTRIES];
  bp_entry_t             ent_l, ent_e, ent_d;
  logic [IDX_W-1:0]      idx_l, idx_e;
  logic [TAG_W-1:0]      tag_l, tag_e;
  logic                  hit_e, brk, wr_en;
  logic [1:0]            ctr_nx;
  logic [XLEN-1:0]       ex_pc4;
  assign idx_l = bus.if_pc[IDX_W+1:2];
  assign tag_l = bus.if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign idx_e = bus.ex_pc[IDX_W+1:2];
  assign tag_e = bus.ex_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign ent_l = tbl_q[idx_l];
  assign ent_e = tbl_q[idx_e];
  assign ex_pc4 = bus.ex_pc + XLEN'(4);
  assign bus.pred_hit    = ent_l.valid && (ent_l.tag == TAG_W_MAX'(tag_l));
  assign bus.pred_taken  = bus.pred_hit && ent_l.ctr[1];
  assign bus.pred_target = bus.pred_taken ? XLEN'(ent_l.target) : bus.if_pc + XLEN'(4);
  assign brk = bus.ex_valid && bus.ex_is_branch;
  assign bus.mispredict = (brk && (bus.ex_taken != bus.ex_pred_taken ||
                                   (bus.ex_taken && bus.ex_target != bus.ex_pred_target))) ||
                          (bus.ex_valid && !bus.ex_is_branch && bus.ex_pred_taken);
  assign bus.redirect_pc = (brk && bus.ex_taken) ? bus.ex_target : ex_pc4;
  assign hit_e = ent_e.valid && (ent_e.tag == TAG_W_MAX'(tag_e));
  // A non-branch only writes to drop an aliasing entry it was wrongly predicted from.
  assign wr_en = bus.ex_valid && (bus.ex_is_branch || (bus.ex_pred_taken && hit_e));
  sat_counter2 u_ctr (
    .ctr      (ent_e.ctr),
    .taken    (bus.ex_taken),
    .ctr_next (ctr_nx)
  );
  always_comb begin
    ent_d        = ent_e;
    ent_d.valid  = bus.ex_is_branch;
    ent_d.tag    = TAG_W_MAX'(tag_e);
    ent_d.ctr    = !bus.ex_is_branch ? ent_e.ctr : hit_e ? ctr_nx : bus.ex_taken ? CTR_WT : CTR_WNT;
    ent_d.target = (!bus.ex_is_branch || (hit_e && !bus.ex_taken)) ? ent_e.target :
                   bus.ex_taken ? XLEN_MAX'(bus.ex_target) : XLEN_MAX'(ex_pc4);
  end
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_q[i].valid <= 1'b0;
        tbl_q[i].ctr   <= CTR_RST;
      end
    end else if (wr_en) begin
      tbl_q[idx_e] <= ent_d;
    end
`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_lookups_q, perf_mispredicts_q;
  always_ff @(posedge clk)
    if (rst) begin
      perf_lookups_q     <= '0;
      perf_mispredicts_q <= '0;
    end else begin
      perf_lookups_q     <= perf_lookups_q + 32'd1;
      perf_mispredicts_q <= perf_mispredicts_q + 32'(bus.mispredict);
    end
  assign perf_lookups     = perf_lookups_q;
  assign perf_mispredicts = perf_mispredicts_q;
`endif
endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb_branch_predictor_btb: directed vectors for the BTB predictor with hand-computed expectations.
module tb_branch_predictor_btb;
  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  always #5 clk = ~clk;
  branch_predictor_btb_if #(.XLEN(32)) bus ();
`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_lookups, perf_mispredicts;
`endif
  branch_predictor_btb #(.XLEN(32), .ENTRIES(64), .TAG_W(10)) dut (
    .clk              (clk),
    .rst              (rst),
`ifdef BP_PERF_CNT_EN
    .perf_lookups     (perf_lookups),
    .perf_mispredicts (perf_mispredicts),
`endif
    .bus              (bus)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic ex(input logic v, input logic br, input logic [31:0] pc, input logic tk,
                    input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    bus.ex_valid       = v;
    bus.ex_is_branch   = br;
    bus.ex_pc          = pc;
    bus.ex_taken       = tk;
    bus.ex_target      = tgt;
    bus.ex_pred_taken  = ptk;
    bus.ex_pred_target = ptgt;
  endtask
  task automatic idle;
    ex(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask
  task automatic look(input string tag, input logic hit, input logic tk, input logic [31:0] tgt);
    check({tag, "_hit"}, 32'(bus.pred_hit), 32'(hit));
    check({tag, "_taken"}, 32'(bus.pred_taken), 32'(tk));
    check({tag, "_tgt"}, bus.pred_target, tgt);
  endtask
  initial begin
    rst = 1'b1;
    idle();
    bus.if_pc = 32'h100;
    tick();
    rst = 1'b0;
    #1;
    look("rst", 1'b0, 1'b0, 32'h104);
    check("rst_mp", 32'(bus.mispredict), 32'd0);
    // cold taken branch, lookup in the same cycle sees the old (empty) entry
    ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
    #1;
    check("cold_mp", 32'(bus.mispredict), 32'd1);
    check("cold_redir", bus.redirect_pc, 32'h40);
    check("cold_same_hit", 32'(bus.pred_hit), 32'd0);
    tick();
    idle();
    #1;
    look("cold_after", 1'b1, 1'b1, 32'h40);
    ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h40, 1'b1, 32'h40);
    #1;
    check("correct_mp", 32'(bus.mispredict), 32'd0);
    repeat (3) tick();
    ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h40, 1'b1, 32'h40);
    #1;
    check("nt_mp", 32'(bus.mispredict), 32'd1);
    check("nt_redir", bus.redirect_pc, 32'h104);
    tick();
    idle();
    #1;
    look("ctr10", 1'b1, 1'b1, 32'h40);
    ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h40, 1'b1, 32'h40);
    tick();
    idle();
    #1;
    look("ctr01", 1'b1, 1'b0, 32'h104);
    // drive to 00 and beyond, then two takens must pass through 01 before predicting taken
    ex(1'b1, 1'b1, 32'h100, 1'b0, 32'h40, 1'b0, 32'h104);
    repeat (3) tick();
    ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
    tick();
    idle();
    #1;
    look("sat_lo", 1'b1, 1'b0, 32'h104);
    ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
    tick();
    idle();
    #1;
    look("sat_up", 1'b1, 1'b1, 32'h40);
    ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h40);
    #1;
    check("tgt_mp", 32'(bus.mispredict), 32'd1);
    check("tgt_redir", bus.redirect_pc, 32'h80);
    tick();
    idle();
    #1;
    look("tgt_new", 1'b1, 1'b1, 32'h80);
    // alias at 0x4100: same index, different tag
    ex(1'b1, 1'b0, 32'h4100, 1'b0, 32'h0, 1'b1, 32'h80);
    #1;
    check("alias_mp", 32'(bus.mispredict), 32'd1);
    check("alias_redir", bus.redirect_pc, 32'h4104);
    tick();
    idle();
    #1;
    look("alias_keep", 1'b1, 1'b1, 32'h80);
    bus.if_pc = 32'h4100;
    #1;
    look("alias_look", 1'b0, 1'b0, 32'h4104);
    bus.if_pc = 32'h100;
    ex(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 32'h80);
    #1;
    check("inv_mp", 32'(bus.mispredict), 32'd1);
    check("inv_redir", bus.redirect_pc, 32'h104);
    tick();
    idle();
    #1;
    look("inv", 1'b0, 1'b0, 32'h104);
    ex(1'b0, 1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h0);
    #1;
    check("bubble_mp", 32'(bus.mispredict), 32'd0);
    tick();
    idle();
    #1;
    check("bubble_no_train", 32'(bus.pred_hit), 32'd0);
    ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    #1;
    check("rw_old_hit", 32'(bus.pred_hit), 32'd0);
    tick();
    idle();
    #1;
    look("rw_new", 1'b1, 1'b1, 32'h80);
    ex(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h80);
    #1;
    check("rw_old_tgt", bus.pred_target, 32'h80);
    tick();
    idle();
    #1;
    check("rw_new_tgt", bus.pred_target, 32'h200);
    bus.if_pc = 32'hFFFF_FFFC;
    ex(1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    look("wrap", 1'b0, 1'b0, 32'h0);
    check("wrap_mp", 32'(bus.mispredict), 32'd0);
    check("wrap_redir", bus.redirect_pc, 32'h0);
    // reset wins over a same-cycle allocation
    bus.if_pc = 32'h100;
    ex(1'b1, 1'b1, 32'h308, 1'b1, 32'h500, 1'b0, 32'h30C);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    #1;
    look("rst2_old", 1'b0, 1'b0, 32'h104);
    bus.if_pc = 32'h308;
    #1;
    look("rst2_new", 1'b0, 1'b0, 32'h30C);
`ifdef BP_PERF_CNT_EN
    check("perf_clr", perf_lookups, 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (i == 3 || i == 7) ex(1'b1, 1'b0, 32'h10, 1'b0, 32'h0, 1'b1, 32'h40);
      else idle();
      tick();
    end
    idle();
    check("perf_lookups", perf_lookups, 32'd10);
    check("perf_mispredicts", perf_mispredicts, 32'd2);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
